// File: rtl/fft_pkg.sv
// Shared types and constants for the 16-point radix-2 FFT sequencer.
package fft_pkg;

  localparam int unsigned N     = 16;
  localparam int unsigned LOG2N = 4;
  localparam int unsigned TW_W  = 3;

  typedef logic [LOG2N-1:0] addr_t;
  typedef logic [TW_W-1:0]  tw_t;

  localparam addr_t LastIdx = addr_t'(N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCalc,
    StDrain,
    StOut
  } state_e;

  function automatic addr_t bitrev4(input addr_t v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Handshake/bus bundle between the FFT sequencer (master) and its datapath/consumer (slave).
interface fft_seq_ctrl_if import fft_pkg::*; ();

  logic       fir_valid;
  logic       ld_we;
  addr_t      ld_addr;
  logic       bf_go;
  addr_t      bf_a;
  addr_t      bf_b;
  tw_t        tw_idx;
  logic       out_valid;
  addr_t      out_addr;
  logic       out_ready;
  logic       busy;
  logic [1:0] stage;
  logic       done;
  logic       ovr;
  logic       ovr_clr;

  modport master (
    input  fir_valid, out_ready, ovr_clr,
    output ld_we, ld_addr, bf_go, bf_a, bf_b, tw_idx,
    output out_valid, out_addr, busy, stage, done, ovr
  );

  modport slave (
    output fir_valid, out_ready, ovr_clr,
    input  ld_we, ld_addr, bf_go, bf_a, bf_b, tw_idx,
    input  out_valid, out_addr, busy, stage, done, ovr
  );

endinterface

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address/twiddle generator for one (stage, k) pair.
module fft_addr_gen import fft_pkg::*; (
  input  logic [1:0] stage,
  input  logic [2:0] k,
  output addr_t      bf_a,
  output addr_t      bf_b,
  output tw_t        tw_idx
);

  addr_t half;
  addr_t j;
  addr_t g;
  addr_t base;

  // half = 8>>stage, so k/half and 2*g*half reduce to shifts by (3-stage) and (4-stage).
  always_comb begin
    half   = addr_t'(4'd8 >> stage);
    j      = {1'b0, k} & (half - 4'd1);
    g      = {1'b0, k} >> (2'd3 - stage);
    base   = g << (3'd4 - {1'b0, stage});
    bf_a   = base | j;
    bf_b   = bf_a + half;
    tw_idx = tw_t'(j << stage);
  end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Load/compute/drain/unload sequencer for a 16-point in-place FFT.
// Define FFT_SEQ_CTRL_BITREV_EN to emit results in natural frequency order.
module fft_seq_ctrl import fft_pkg::*; #(
  parameter int unsigned BF_LAT = 2
) (
  input logic            clk,
  input logic            rst,
  fft_seq_ctrl_if.master bus
);

  localparam logic [2:0] DrainLast = 3'(BF_LAT - 1);

  state_e     state_q;
  addr_t      cnt_q;
  addr_t      idx_q;
  logic [1:0] stage_q;
  logic [2:0] k_q;
  logic [2:0] drain_q;
  logic       done_q;
  logic       ovr_q;

  logic       accept;
  logic       calc;
  addr_t      gen_a;
  addr_t      gen_b;
  tw_t        gen_tw;
  addr_t      out_map;

  // The done cycle sits in IDLE but still refuses samples.
  assign accept = (state_q == StIdle && !done_q) || state_q == StLoad;
  assign calc   = state_q == StCalc;

  fft_addr_gen u_addr_gen (
    .stage  (stage_q),
    .k      (k_q),
    .bf_a   (gen_a),
    .bf_b   (gen_b),
    .tw_idx (gen_tw)
  );

`ifdef FFT_SEQ_CTRL_BITREV_EN
  assign out_map = bitrev4(idx_q);
`else
  assign out_map = idx_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      k_q     <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.fir_valid && !accept) begin
        ovr_q <= 1'b1;
      end else if (bus.ovr_clr) begin
        ovr_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (bus.fir_valid && accept) begin
            state_q <= StLoad;
            cnt_q   <= addr_t'(1);
          end
        end
        StLoad: begin
          if (bus.fir_valid) begin
            if (cnt_q == LastIdx) begin
              state_q <= StCalc;
              cnt_q   <= '0;
              stage_q <= '0;
              k_q     <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StCalc: begin
          k_q <= k_q + 1'b1;
          if (k_q == 3'd7) begin
            state_q <= StDrain;
            drain_q <= '0;
          end
        end
        StDrain: begin
          if (drain_q == DrainLast) begin
            if (stage_q == 2'd3) begin
              state_q <= StOut;
              stage_q <= '0;
              idx_q   <= '0;
            end else begin
              state_q <= StCalc;
              stage_q <= stage_q + 1'b1;
              k_q     <= '0;
            end
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        StOut: begin
          if (bus.out_ready) begin
            if (idx_q == LastIdx) begin
              state_q <= StIdle;
              idx_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // ld_we is gated by rst so every output is low while reset is held.
  always_comb begin
    bus.ld_we     = rst && bus.fir_valid && accept;
    bus.ld_addr   = cnt_q;
    bus.bf_go     = calc;
    bus.bf_a      = calc ? gen_a : '0;
    bus.bf_b      = calc ? gen_b : '0;
    bus.tw_idx    = calc ? gen_tw : '0;
    bus.out_valid = state_q == StOut;
    bus.out_addr  = (state_q == StOut) ? out_map : '0;
    bus.busy      = state_q != StIdle;
    bus.stage     = stage_q;
    bus.done      = done_q;
    bus.ovr       = ovr_q;
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Randomized bench for fft_seq_ctrl against a frame-level reference model.
module tb_fft_seq_ctrl;
  import fft_pkg::*;

  localparam int unsigned BfLat  = 2;
  localparam int unsigned Period = 8 + BfLat;
  localparam int PhIdle = 0, PhLoad = 1, PhComp = 2, PhOut = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  fft_seq_ctrl_if bus ();

  fft_seq_ctrl #(.BF_LAT(BfLat)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a frame is 16 accepted samples, 4*Period compute cycles, 16 handshakes.
  int m_phase, m_cnt, m_t, m_i;
  bit m_done, m_ovr;
  int tab_a[4][8], tab_b[4][8], tab_w[4][8];

  int pct_ld, pct_busy, pct_rdy, pct_clr;
  bit gap_mode = 0, gap_tog = 1;
  int stall_left = 0;
  int cyc = 0, done_seen = 0;
  int wr_cyc = 0, bf_cyc = 0;
  bit seen_bf = 1, seen_ov = 1, pend_ovr_win = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int exp_oaddr(input int i);
    int r;
    r = i;
`ifdef FFT_SEQ_CTRL_BITREV_EN
    r = 0;
    for (int b = 0; b < 4; b++) if (((i >> b) & 1) != 0) r |= 1 << (3 - b);
`endif
    return r;
  endfunction

  // Butterflies of a stage: every a whose distance-half partner lies above it, in ascending a.
  task automatic build_tab();
    for (int s = 0; s < 4; s++) begin
      int half, n;
      half = 8 >> s;
      n = 0;
      for (int a = 0; a < 16; a++) begin
        if (((a / half) % 2) == 0) begin
          tab_a[s][n] = a;
          tab_b[s][n] = a + half;
          tab_w[s][n] = (a % half) << s;
          n++;
        end
      end
    end
  endtask

  task automatic set_mode(input int ld, input int bz, input int rd, input int cl);
    pct_ld = ld; pct_busy = bz; pct_rdy = rd; pct_clr = cl;
  endtask

  task automatic model_reset();
    m_phase = PhIdle; m_cnt = 0; m_t = 0; m_i = 0; m_done = 0; m_ovr = 0;
    seen_bf = 1; seen_ov = 1; pend_ovr_win = 0;
  endtask

  task automatic chk_all_zero();
    chk("rst_ld_we", bus.ld_we, 0);       chk("rst_ld_addr", bus.ld_addr, 0);
    chk("rst_bf_go", bus.bf_go, 0);       chk("rst_bf_a", bus.bf_a, 0);
    chk("rst_bf_b", bus.bf_b, 0);         chk("rst_tw_idx", bus.tw_idx, 0);
    chk("rst_out_valid", bus.out_valid, 0); chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_busy", bus.busy, 0);         chk("rst_stage", bus.stage, 0);
    chk("rst_done", bus.done, 0);         chk("rst_ovr", bus.ovr, 0);
  endtask

  // Called at posedge+1; asserts reset mid-cycle and releases it away from an edge.
  task automatic async_reset();
    rst = 1'b0;
    bus.fir_valid = 1'b0; bus.out_ready = 1'b0; bus.ovr_clr = 1'b0;
    #1;
    chk_all_zero();
    model_reset();
    @(posedge clk); cyc++; #1;
    rst = 1'b1;
    @(posedge clk); cyc++; #1;
  endtask

  // One clock: drive inputs, check predictions, then advance the model across the edge.
  task automatic step();
    logic fv, rdy, clr, e_we, e_go, acc;
    int s, w, e_a, e_b, e_tw, e_stage, e_oaddr;

    if (pend_ovr_win) chk("ovr_set_wins", bus.ovr, 1);
    pend_ovr_win = 0;

    if (m_phase == PhIdle || m_phase == PhLoad) begin
      if (gap_mode) begin
        fv = gap_tog; gap_tog = ~gap_tog;
      end else begin
        fv = ($urandom % 100) < pct_ld;
      end
    end else begin
      fv = ($urandom % 100) < pct_busy;
    end
    if (m_phase == PhOut && m_i == 4 && stall_left > 0) begin
      rdy = 1'b0; stall_left--;
    end else begin
      rdy = ($urandom % 100) < pct_rdy;
    end
    clr = ($urandom % 100) < pct_clr;
    bus.fir_valid = fv; bus.out_ready = rdy; bus.ovr_clr = clr;
    #1;

    acc  = (m_phase == PhIdle && !m_done) || m_phase == PhLoad;
    e_we = fv && acc;
    s = 0; w = 0; e_go = 0; e_a = 0; e_b = 0; e_tw = 0;
    if (m_phase == PhComp) begin
      s = m_t / Period;
      w = m_t % Period;
      e_go = w < 8;
      if (e_go) begin
        e_a = tab_a[s][w]; e_b = tab_b[s][w]; e_tw = tab_w[s][w];
      end
    end
    e_stage = (m_phase == PhComp) ? s : 0;
    e_oaddr = (m_phase == PhOut) ? exp_oaddr(m_i) : 0;

    chk("ld_we", bus.ld_we, e_we);
    chk("ld_addr", bus.ld_addr, m_cnt);
    chk("bf_go", bus.bf_go, e_go);
    chk("bf_a", bus.bf_a, e_a);
    chk("bf_b", bus.bf_b, e_b);
    chk("tw_idx", bus.tw_idx, e_tw);
    chk("stage", bus.stage, e_stage);
    chk("busy", bus.busy, m_phase != PhIdle);
    chk("out_valid", bus.out_valid, m_phase == PhOut);
    chk("out_addr", bus.out_addr, e_oaddr);
    chk("done", bus.done, m_done);
    chk("ovr", bus.ovr, m_ovr);

    if (e_go && s == 1 && w == 5) begin
      chk("s1k5_a", bus.bf_a, 9); chk("s1k5_b", bus.bf_b, 13); chk("s1k5_tw", bus.tw_idx, 2);
    end
    if (e_go && s == 3 && w == 7) begin
      chk("s3k7_a", bus.bf_a, 14); chk("s3k7_b", bus.bf_b, 15); chk("s3k7_tw", bus.tw_idx, 0);
    end
    if (m_phase == PhOut && m_i == 4 && !rdy) chk("stall_addr", bus.out_addr, exp_oaddr(4));
    if (m_phase == PhOut && fv && clr) pend_ovr_win = 1;

    if (e_we && m_cnt == 15) begin
      wr_cyc = cyc; seen_bf = 0; seen_ov = 0;
    end
    if (bus.bf_go === 1'b1 && !seen_bf) begin
      seen_bf = 1; bf_cyc = cyc;
      chk("bf_go_latency", cyc - wr_cyc, 1);
    end
    if (bus.out_valid === 1'b1 && !seen_ov) begin
      seen_ov = 1;
      chk("out_valid_latency", cyc - bf_cyc, 4 * Period);
    end
    if (bus.done === 1'b1) done_seen++;

    @(posedge clk);
    cyc++;
    if (fv && !acc) m_ovr = 1;
    else if (clr) m_ovr = 0;
    m_done = 0;
    case (m_phase)
      PhIdle: if (fv && acc) begin m_phase = PhLoad; m_cnt = 1; end
      PhLoad: begin
        if (fv) begin
          if (m_cnt == 15) begin m_phase = PhComp; m_t = 0; m_cnt = 0; end
          else m_cnt++;
        end
      end
      PhComp: begin
        if (m_t == 4 * Period - 1) begin m_phase = PhOut; m_i = 0; end
        else m_t++;
      end
      default: begin
        if (rdy) begin
          if (m_i == 15) begin m_phase = PhIdle; m_done = 1; m_i = 0; end
          else m_i++;
        end
      end
    endcase
    #1;
  endtask

  task automatic run_frame();
    int guard;
    bit left;
    guard = 0; left = 0; done_seen = 0;
    while (!(left && m_phase == PhIdle) && guard < 1000) begin
      step();
      guard++;
      if (m_phase != PhIdle) left = 1;
    end
    if (guard >= 1000) chk("frame_timeout", guard, 0);
    step();
    chk("done_once", done_seen, 1);
  endtask

  task automatic run_to_stage2();
    int guard;
    guard = 0;
    while (!(m_phase == PhComp && m_t / Period == 2) && guard < 500) begin
      step();
      guard++;
    end
    if (guard >= 500) chk("stage2_timeout", guard, 0);
  endtask

  initial begin
    build_tab();
    model_reset();
    bus.fir_valid = 1'b0; bus.out_ready = 1'b0; bus.ovr_clr = 1'b0;
    #1;
    async_reset();

    set_mode(100, 0, 100, 0);
    run_frame();

    gap_mode = 1; gap_tog = 1;
    run_frame();
    gap_mode = 0;

    stall_left = 3;
    set_mode(100, 0, 100, 0);
    run_frame();

    set_mode(100, 40, 80, 40);
    run_frame();

    set_mode(100, 0, 100, 0);
    run_to_stage2();
    async_reset();
    run_frame();

    for (int f = 0; f < 6; f++) begin
      set_mode($urandom_range(30, 100), $urandom_range(0, 50),
               $urandom_range(30, 100), $urandom_range(0, 50));
      run_frame();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
